// File: rtl/player_input_conditioner.sv
// rtl/player_input_conditioner.sv - per-player button synchronizer, debouncer, pulse generator and direction resolver
module player_input_conditioner #(
    parameter int NUM_BTNS        = 7,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] raw_btns,
    output logic [NUM_BTNS-1:0] btn_state,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTNS-1:0] s1;
    logic [NUM_BTNS-1:0] s2;
    logic [NUM_BTNS-1:0] stable;
    logic [NUM_BTNS-1:0] stable_nxt;
    logic [NUM_BTNS-1:0] update;
    logic [NUM_BTNS-1:0] press_now;
    logic [NUM_BTNS-1:0] state_nxt;
    logic [CNT_W-1:0]    cnt [NUM_BTNS];
    logic                last_h;
    logic                last_v;
    logic                last_h_nxt;
    logic                last_v_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw_btns;
            s2 <= s1;
        end
    end

    always_comb begin
        update = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            update[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_MAX);
        end
        stable_nxt = (stable & ~update) | (s2 & update);
        press_now  = update & s2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                if ((s2[i] == stable[i]) || update[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Left/up take priority when both members of a pair are pressed together.
    always_comb begin
        last_h_nxt = last_h;
        last_v_nxt = last_v;
        if (press_now[1]) begin
            last_h_nxt = 1'b0;
        end else if (press_now[2]) begin
            last_h_nxt = 1'b1;
        end
        if (press_now[3]) begin
            last_v_nxt = 1'b0;
        end else if (press_now[4]) begin
            last_v_nxt = 1'b1;
        end

        state_nxt = stable_nxt;
        if (stable_nxt[1] && stable_nxt[2]) begin
            state_nxt[1] = ~last_h_nxt;
            state_nxt[2] = last_h_nxt;
        end
        if (stable_nxt[3] && stable_nxt[4]) begin
            state_nxt[3] = ~last_v_nxt;
            state_nxt[4] = last_v_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable      <= '0;
            last_h      <= 1'b0;
            last_v      <= 1'b0;
            btn_state   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            stable      <= stable_nxt;
            last_h      <= last_h_nxt;
            last_v      <= last_v_nxt;
            btn_state   <= state_nxt;
            btn_press   <= update & s2;
            btn_release <= update & ~s2;
        end
    end

endmodule

// File: tb/tb_player_input_conditioner.sv
// tb/tb_player_input_conditioner.sv - directed self-checking bench for player_input_conditioner
module tb_player_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] raw_btns;
    logic [6:0] btn_state;
    logic [6:0] btn_press;
    logic [6:0] btn_release;

    int errors = 0;
    int checks = 0;

    player_input_conditioner #(
        .NUM_BTNS       (7),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_btns   (raw_btns),
        .btn_state  (btn_state),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset    = 1'b0;
        raw_btns = 7'h00;
        tick(2);
        checks++;
        if ({btn_state, btn_press, btn_release} !== 21'h0) begin
            $display("FAIL reset_outputs got=%h want=0", {btn_state, btn_press, btn_release});
            errors++;
        end
        reset = 1'b1;
        tick(2);
    endtask

    task automatic test_clean_press;
        raw_btns[5] = 1'b1;
        tick(5);
        checks++;
        if (btn_state[5] !== 1'b0 || btn_press[5] !== 1'b0) begin
            $display("FAIL press_early state=%b press=%b want=0,0", btn_state[5], btn_press[5]);
            errors++;
        end
        tick(1);
        checks++;
        if (btn_state !== 7'h20 || btn_press !== 7'h20) begin
            $display("FAIL press_edge state=%h press=%h want=20,20", btn_state, btn_press);
            errors++;
        end
        tick(1);
        checks++;
        if (btn_state !== 7'h20 || btn_press !== 7'h00) begin
            $display("FAIL press_one_cycle state=%h press=%h want=20,00", btn_state, btn_press);
            errors++;
        end
        raw_btns[5] = 1'b0;
        tick(5);
        checks++;
        if (btn_state !== 7'h20 || btn_release !== 7'h00) begin
            $display("FAIL release_early state=%h rel=%h want=20,00", btn_state, btn_release);
            errors++;
        end
        tick(1);
        checks++;
        if (btn_state !== 7'h00 || btn_release !== 7'h20) begin
            $display("FAIL release_edge state=%h rel=%h want=00,20", btn_state, btn_release);
            errors++;
        end
        tick(1);
        checks++;
        if (btn_release !== 7'h00) begin
            $display("FAIL release_one_cycle rel=%h want=00", btn_release);
            errors++;
        end
    endtask

    task automatic test_bounce;
        logic bad;
        bad = 1'b0;
        for (int p = 0; p < 4; p++) begin
            raw_btns[0] = (p % 2 == 0);
            for (int c = 0; c < 3; c++) begin
                tick(1);
                if (btn_state !== 7'h00 || btn_press !== 7'h00 || btn_release !== 7'h00) bad = 1'b1;
            end
        end
        for (int c = 0; c < 4; c++) begin
            tick(1);
            if (btn_state !== 7'h00 || btn_press !== 7'h00 || btn_release !== 7'h00) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            $display("FAIL bounce_reject output changed during bounce train, want all 0");
            errors++;
        end
        raw_btns[0] = 1'b1;
        tick(5);
        checks++;
        if (btn_state[0] !== 1'b0) begin
            $display("FAIL bounce_hold_early state0=%b want=0", btn_state[0]);
            errors++;
        end
        tick(1);
        checks++;
        if (btn_state !== 7'h01 || btn_press !== 7'h01) begin
            $display("FAIL bounce_hold_accept state=%h press=%h want=01,01", btn_state, btn_press);
            errors++;
        end
        raw_btns[0] = 1'b0;
        tick(8);
    endtask

    task automatic test_direction;
        raw_btns[1] = 1'b1;
        tick(6);
        checks++;
        if (btn_state[2:1] !== 2'b01) begin
            $display("FAIL dir_left state=%b want=01", btn_state[2:1]);
            errors++;
        end
        raw_btns[2] = 1'b1;
        tick(5);
        checks++;
        if (btn_state[2:1] !== 2'b01) begin
            $display("FAIL dir_right_early state=%b want=01", btn_state[2:1]);
            errors++;
        end
        tick(1);
        checks++;
        if (btn_state[2:1] !== 2'b10 || btn_press !== 7'h04) begin
            $display("FAIL dir_right_wins state=%b press=%h want=10,04", btn_state[2:1], btn_press);
            errors++;
        end
        raw_btns[2] = 1'b0;
        tick(5);
        checks++;
        if (btn_state[2:1] !== 2'b10) begin
            $display("FAIL dir_rel_early state=%b want=10", btn_state[2:1]);
            errors++;
        end
        tick(1);
        checks++;
        if (btn_state[2:1] !== 2'b01 || btn_release !== 7'h04) begin
            $display("FAIL dir_loser_returns state=%b rel=%h want=01,04", btn_state[2:1], btn_release);
            errors++;
        end
        raw_btns[1] = 1'b0;
        tick(6);
        checks++;
        if (btn_state !== 7'h00) begin
            $display("FAIL dir_all_released state=%h want=00", btn_state);
            errors++;
        end
        raw_btns[4:3] = 2'b11;
        tick(6);
        checks++;
        if (btn_state[4:3] !== 2'b01 || btn_press !== 7'h18) begin
            $display("FAIL dir_up_down_tie state=%b press=%h want=01,18", btn_state[4:3], btn_press);
            errors++;
        end
        raw_btns[4:3] = 2'b00;
        tick(8);
    endtask

    task automatic test_async_reset;
        raw_btns[6] = 1'b1;
        tick(6);
        checks++;
        if (btn_state !== 7'h40) begin
            $display("FAIL rst_pre_state state=%h want=40", btn_state);
            errors++;
        end
        raw_btns[0] = 1'b1;
        tick(3);
        reset = 1'b0;
        #1;
        checks++;
        if ({btn_state, btn_press, btn_release} !== 21'h0) begin
            $display("FAIL rst_async_clear got=%h want=0", {btn_state, btn_press, btn_release});
            errors++;
        end
        tick(2);
        reset = 1'b1;
        tick(5);
        checks++;
        if (btn_press !== 7'h00 || btn_state !== 7'h00) begin
            $display("FAIL rst_repress_early press=%h state=%h want=00,00", btn_press, btn_state);
            errors++;
        end
        tick(1);
        checks++;
        if (btn_press !== 7'h41 || btn_state !== 7'h41) begin
            $display("FAIL rst_repress press=%h state=%h want=41,41", btn_press, btn_state);
            errors++;
        end
        raw_btns = 7'h00;
        tick(8);
    endtask

    task automatic test_all_seven;
        raw_btns = 7'h7F;
        tick(5);
        checks++;
        if (btn_press !== 7'h00) begin
            $display("FAIL all7_early press=%h want=00", btn_press);
            errors++;
        end
        tick(1);
        checks++;
        if (btn_press !== 7'h7F || btn_state !== 7'b1101011) begin
            $display("FAIL all7_press press=%h state=%h want=7f,6b", btn_press, btn_state);
            errors++;
        end
        tick(1);
        checks++;
        if (btn_press !== 7'h00 || btn_state !== 7'b1101011) begin
            $display("FAIL all7_hold press=%h state=%h want=00,6b", btn_press, btn_state);
            errors++;
        end
        raw_btns = 7'h00;
        tick(6);
        checks++;
        if (btn_release !== 7'h7F || btn_state !== 7'h00) begin
            $display("FAIL all7_release rel=%h state=%h want=7f,00", btn_release, btn_state);
            errors++;
        end
        tick(2);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_direction();
        test_async_reset();
        test_all_seven();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/player_input_conditioner.md
# player_input_conditioner

Per-player button front end that turns seven raw, asynchronous push-button inputs into clean, debounced signals for the core game logic. It synchronizes and debounces each button, then resolves opposing directions (left/right, up/down) with last-pressed-wins priority. It also emits one-cycle press and release pulses. The design instantiates one copy per player; each copy's `btn_state` drives that player's 7-bit input bus on the game core.

## Interface
- `NUM_BTNS`, default 7. Button count. The bit map below is fixed for 7.
- `DEBOUNCE_CYCLES`, default 1_000_000. Consecutive stable cycles required to accept a change (10 ms at 100 MHz). Must be ≥ 1.
- `CNT_W`, default 20. Counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES−1.

Ports:
- `clk`  in  1. System clock.
- `reset`  in  1. Asynchronous, active-low reset.
- `raw_btns`  in  NUM_BTNS. Raw pin levels, asynchronous, 1 = pressed. Bit map: [0] center, [1] left, [2] right, [3] up, [4] down, [5] attack, [6] shield.
- `btn_state`  out  NUM_BTNS. Debounced levels after direction resolution. Feeds the game core.
- `btn_press`  out  NUM_BTNS. One-cycle pulse on each debounced 0→1, taken before resolution.
- `btn_release`  out  NUM_BTNS. One-cycle pulse on each debounced 1→0, taken before resolution.

## Operation
- **Synchronizer.** Two flops per bit: `s1 <= raw`, `s2 <= s1`. No logic sits between them.
- **Debouncer.** Each bit holds `stable` and `cnt[CNT_W-1:0]`. On every clock:
  - If `s2 == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0`, and an update event fires.
  - Else: `cnt <= cnt + 1`.
  - Any glitch shorter than the window clears the counter, and `stable` is unchanged.
- **Pulses.** These are registered.
  - `btn_press[i] <= update_i & s2[i]`.
  - `btn_release[i] <= update_i & ~s2[i]`.
  - Each pulse goes high in the same cycle that `stable[i]` first shows the new value, and lasts exactly one cycle.
- **Direction resolution.** This applies to pairs (left=1, right=2) and (up=3, down=4). One `last` bit per pair records the most recent debounced press.
  - A press of the second member of the pair sets `last` to 1. A press of the first member sets it to 0.
  - If both members are pressed in the same cycle, the first member (left/up) wins and `last <= 0`.
  - When both `stable` bits are 1, only the member selected by `last` appears in `btn_state`.
  - When only one is stable-high, it passes through unchanged.
  - Releasing the winner while the loser is still held makes the loser appear immediately. No new debounce window is required.
- **Passthrough.** `btn_state[0,5,6]` equal `stable[0,5,6]` directly.
- **Registration.** `btn_state` is registered and updates in the same cycle as `stable`.

## Timing
- **Reset.** While `reset == 0`, every register clears asynchronously: `s1`, `s2`, `stable`, `cnt`, `last`, `btn_state`, `btn_press`, `btn_release` are all 0.
- **Latency.** The raw level must be held from capture edge E0, the first edge at which `s1` sees the new value.
  - `btn_state`, `stable` and the pulse all change at edge E0 + DEBOUNCE_CYCLES + 1.
  - Total: DEBOUNCE_CYCLES + 2 edges counting E0.
- **Glitch rejection.** A bounce lasting k ≤ DEBOUNCE_CYCLES−1 cycles at `s2` produces no output change and no pulse.
- **Reset mid-count.** A partial count is discarded. A button held through reset release is reported as a fresh press, with a `btn_press` pulse, DEBOUNCE_CYCLES + 2 edges after the first post-reset edge.
- **Counter bound.** The counter never exceeds DEBOUNCE_CYCLES−1, so it never wraps.
- **Independence.** Bits are independent except for the pair resolution. Simultaneous updates on different bits all pulse in the same cycle.

## Test plan
Scenarios 1–5 run with DEBOUNCE_CYCLES=4.

1. **Clean press.** Raise `raw_btns[5]` and hold it. Required: `btn_state[5]` and `btn_press[5]` rise at the 6th edge after capture, and `btn_press[5]` is high for exactly 1 cycle. Then drop the input. Required: `btn_release[5]` pulses 6 edges after that capture.
2. **Bounce rejection.** Toggle `raw_btns[0]` 1,0,1,0 with each level held 3 cycles. Required: `btn_state` stays 0 and no pulses fire. Then hold 1. Required: the press is accepted 6 edges after the last capture.
3. **Direction priority.**
   - Hold left and accept it, then hold right and accept it. Required: `btn_state[2:1]` = 2'b10.
   - Release right. Required: `btn_state[2:1]` = 2'b01 in the same cycle that `stable[2]` clears.
   - Press up and down in the same cycle. Required: `btn_state[4:3]` = 2'b01.
4. **Async reset mid-operation.** Assert `reset` low mid-count while `btn_state[6]`=1. Required: all outputs are 0 within the same cycle, before the next edge. Release reset with the button still held. Required: `btn_press[6]` pulses 6 edges later.
5. **All seven simultaneously.** Press all seven raw inputs at once. Required: `btn_press` = 7'h7F for one cycle and `btn_state` = 7'b1101011 (right and down masked).
6. **Default-parameter smoke test.** With DEBOUNCE_CYCLES=1_000_000, a 5 ms bounce train is rejected and a 12 ms hold is accepted at exactly 1_000_002 edges.
